// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with a
// ready/valid memory stall and optional wait limit. Define MULTICYCLE_CONTROL_TRAP_EN to trap on unsupported instructions.
module multicycle_control #(
  parameter int ALU_OP_W   = 3,
  parameter int WAIT_LIMIT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_shift,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                mem_timeout,
`ifdef MULTICYCLE_CONTROL_TRAP_EN
  output logic                illegal,
`endif
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam int          CNT_W  = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [2:0]  OP_AND = 3'b000;
  localparam logic [2:0]  OP_OR  = 3'b001;
  localparam logic [2:0]  OP_ADD = 3'b010;
  localparam logic [2:0]  OP_SLL = 3'b100;
  localparam logic [2:0]  OP_SUB = 3'b110;
  localparam logic [2:0]  OP_SLT = 3'b111;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_wait_state;
  logic             w_timeout;
  logic             w_supported;

  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      6'h23, 6'h2b, 6'h08, 6'h04, 6'h02: ok = 1'b1;
      6'h00: begin
        case (fn)
          6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] funct_alu_op(input logic [5:0] fn);
    logic [2:0] code;
    case (fn)
      6'h00:   code = OP_SLL;
      6'h20:   code = OP_ADD;
      6'h22:   code = OP_SUB;
      6'h24:   code = OP_AND;
      6'h25:   code = OP_OR;
      6'h2a:   code = OP_SLT;
      default: code = OP_ADD;
    endcase
    return code;
  endfunction

  assign w_supported  = is_supported(opcode, funct);
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // Completion wins over expiry: timeout only fires when mem_ready is low at the limit.
  assign w_timeout    = (WAIT_LIMIT != 0) && w_wait_state && !mem_ready &&
                        (r_wait_cnt == CNT_W'(WAIT_LIMIT));
  assign state        = r_state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Memory wait counter: counts stalled cycles, saturates, clears on exit or expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_wait_state && !mem_ready && !w_timeout) begin
      if (r_wait_cnt != {CNT_W{1'b1}}) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Next-state and output decode; while rst_n is low only mem_read is driven
  always_comb begin
    w_next_state = S_FETCH;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    pc_en        = 1'b0;
    pc_src       = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu_op       = '0;
    alu_shift    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    instr_done   = 1'b0;
    mem_timeout  = 1'b0;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    illegal      = 1'b0;
`endif
    if (rst_n) begin
      mem_timeout = w_timeout;
      case (r_state)
        S_FETCH: begin
          mem_read     = 1'b1;
          alu_src_b    = 2'd1;
          alu_op       = ALU_OP_W'(OP_ADD);
          ir_write     = mem_ready;
          pc_en        = mem_ready;
          w_next_state = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          alu_op    = ALU_OP_W'(OP_ADD);
          if (!w_supported) begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            w_next_state = S_TRAP;
`else
            instr_done   = 1'b1;
            w_next_state = S_FETCH;
`endif
          end else begin
            case (opcode)
              6'h23, 6'h2b: w_next_state = S_MEMADR;
              6'h00:        w_next_state = S_RTYPE;
              6'h08:        w_next_state = S_ADDIEX;
              6'h04:        w_next_state = S_BRANCH;
              6'h02:        w_next_state = S_JUMP;
              default:      w_next_state = S_FETCH;
            endcase
          end
        end
        S_MEMADR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'd2;
          alu_op       = ALU_OP_W'(OP_ADD);
          w_next_state = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_read     = 1'b1;
          i_or_d       = 1'b1;
          w_next_state = (mem_ready || w_timeout) ? (mem_ready ? S_MEMWB : S_FETCH) : S_MEMRD;
        end
        S_MEMWB: begin
          reg_write    = 1'b1;
          mem_to_reg   = 1'b1;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end
        S_MEMWR: begin
          mem_write    = 1'b1;
          i_or_d       = 1'b1;
          instr_done   = mem_ready;
          w_next_state = (mem_ready || w_timeout) ? S_FETCH : S_MEMWR;
        end
        S_RTYPE: begin
          alu_src_a    = 1'b1;
          alu_op       = ALU_OP_W'(funct_alu_op(funct));
          alu_shift    = (funct == 6'h00);
          w_next_state = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write    = 1'b1;
          reg_dst      = 1'b1;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'd2;
          alu_op       = ALU_OP_W'(OP_ADD);
          w_next_state = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write    = 1'b1;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a    = 1'b1;
          alu_op       = ALU_OP_W'(OP_SUB);
          pc_src       = 2'd1;
          pc_en        = zero;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end
        S_JUMP: begin
          pc_src       = 2'd2;
          pc_en        = 1'b1;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        S_TRAP: begin
          illegal      = 1'b1;
          w_next_state = S_TRAP;
        end
`endif
        default: begin
          w_next_state = S_FETCH;
        end
      endcase
    end else begin
      mem_read = 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one instance with unlimited wait, one with WAIT_LIMIT = 2.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready, mem_ready_t;

  logic       mem_read, mem_write, i_or_d, ir_write, pc_en, alu_src_a, alu_shift;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, mem_timeout;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  logic       mem_read_t, mem_write_t, i_or_d_t, ir_write_t, pc_en_t, alu_src_a_t, alu_shift_t;
  logic       reg_dst_t, mem_to_reg_t, reg_write_t, instr_done_t, mem_timeout_t;
  logic [1:0] pc_src_t, alu_src_b_t;
  logic [2:0] alu_op_t;
  logic [3:0] state_t;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
  logic       illegal, illegal_t;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt;
  int irw_cnt;

  always #5 clk = ~clk;

  multicycle_control #(.ALU_OP_W(3), .WAIT_LIMIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .alu_shift(alu_shift), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instr_done(instr_done), .mem_timeout(mem_timeout),
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    .illegal(illegal),
`endif
    .state(state)
  );

  multicycle_control #(.ALU_OP_W(3), .WAIT_LIMIT(2)) dut_to (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready_t),
    .mem_read(mem_read_t), .mem_write(mem_write_t), .i_or_d(i_or_d_t), .ir_write(ir_write_t),
    .pc_en(pc_en_t), .pc_src(pc_src_t), .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t),
    .alu_op(alu_op_t), .alu_shift(alu_shift_t), .reg_dst(reg_dst_t), .mem_to_reg(mem_to_reg_t),
    .reg_write(reg_write_t), .instr_done(instr_done_t), .mem_timeout(mem_timeout_t),
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    .illegal(illegal_t),
`endif
    .state(state_t)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    mem_ready = 1'b1; mem_ready_t = 1'b1;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd1);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_alu_src_b", 32'(alu_src_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    #8 rst_n = 1'b1;
    #1;
    // add: 0,1,6,7
    done_cnt = 0;
    check("add_c1_state", 32'(state), 32'd0);
    check("add_c1_ir_write", 32'(ir_write), 32'd1);
    check("add_c1_pc_en", 32'(pc_en), 32'd1);
    check("add_c1_alu_src_b", 32'(alu_src_b), 32'd1);
    check("add_c1_alu_op", 32'(alu_op), 32'd2);
    done_cnt += int'(instr_done);
    cyc();
    check("add_c2_state", 32'(state), 32'd1);
    check("add_c2_alu_src_b", 32'(alu_src_b), 32'd3);
    done_cnt += int'(instr_done);
    cyc();
    check("add_c3_state", 32'(state), 32'd6);
    check("add_c3_alu_op", 32'(alu_op), 32'd2);
    check("add_c3_alu_src_a", 32'(alu_src_a), 32'd1);
    check("add_c3_alu_src_b", 32'(alu_src_b), 32'd0);
    done_cnt += int'(instr_done);
    cyc();
    check("add_c4_state", 32'(state), 32'd7);
    check("add_c4_reg_write", 32'(reg_write), 32'd1);
    check("add_c4_reg_dst", 32'(reg_dst), 32'd1);
    check("add_c4_instr_done", 32'(instr_done), 32'd1);
    done_cnt += int'(instr_done);
    check("add_done_count", 32'(done_cnt), 32'd1);
    cyc();
    check("add_back_fetch", 32'(state), 32'd0);

    // lw with three stall cycles in MEMRD
    opcode = 6'h23;
    cyc(); cyc();
    check("lw_memadr_state", 32'(state), 32'd2);
    check("lw_memadr_src_b", 32'(alu_src_b), 32'd2);
    mem_ready = 1'b0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      #1;
      check($sformatf("lw_memrd%0d_state", k), 32'(state), 32'd3);
      check($sformatf("lw_memrd%0d_rd", k), 32'(mem_read), 32'd1);
      check($sformatf("lw_memrd%0d_iord", k), 32'(i_or_d), 32'd1);
      check($sformatf("lw_memrd%0d_to", k), 32'(mem_timeout), 32'd0);
      cyc();
    end
    check("lw_memwb_state", 32'(state), 32'd4);
    check("lw_memwb_m2r", 32'(mem_to_reg), 32'd1);
    check("lw_memwb_rw", 32'(reg_write), 32'd1);
    check("lw_memwb_dst", 32'(reg_dst), 32'd0);
    cyc();

    // beq taken / not taken
    opcode = 6'h04; zero = 1'b1;
    cyc(); cyc();
    check("beq1_state", 32'(state), 32'd10);
    check("beq1_pc_en", 32'(pc_en), 32'd1);
    check("beq1_pc_src", 32'(pc_src), 32'd1);
    check("beq1_alu_op", 32'(alu_op), 32'd6);
    check("beq1_done", 32'(instr_done), 32'd1);
    cyc();
    zero = 1'b0;
    cyc(); cyc();
    check("beq0_pc_en", 32'(pc_en), 32'd0);
    check("beq0_pc_src", 32'(pc_src), 32'd1);
    cyc();

    // j
    opcode = 6'h02;
    cyc(); cyc();
    check("j_state", 32'(state), 32'd11);
    check("j_pc_src", 32'(pc_src), 32'd2);
    check("j_pc_en", 32'(pc_en), 32'd1);
    cyc();

    // slt and sll
    opcode = 6'h00; funct = 6'h2a;
    cyc(); cyc();
    check("slt_alu_op", 32'(alu_op), 32'd7);
    cyc(); cyc();
    funct = 6'h00;
    cyc(); cyc();
    check("sll_alu_op", 32'(alu_op), 32'd4);
    check("sll_shift", 32'(alu_shift), 32'd1);
    cyc(); cyc();

    // addi
    opcode = 6'h08;
    cyc(); cyc();
    check("addi_ex_state", 32'(state), 32'd8);
    check("addi_ex_src_b", 32'(alu_src_b), 32'd2);
    cyc();
    check("addi_wb_state", 32'(state), 32'd9);
    check("addi_wb_rw", 32'(reg_write), 32'd1);
    check("addi_wb_dst", 32'(reg_dst), 32'd0);
    cyc();

    // unsupported opcode
    opcode = 6'h3f;
    cyc();
    check("ill_decode_state", 32'(state), 32'd1);
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    check("ill_decode_done", 32'(instr_done), 32'd0);
    cyc();
    check("ill_trap_state", 32'(state), 32'd12);
    check("ill_trap_flag", 32'(illegal), 32'd1);
    cyc(); cyc();
    check("ill_trap_hold", 32'(state), 32'd12);
    check("ill_trap_flag_hold", 32'(illegal), 32'd1);
    check("ill_trap_mem_read", 32'(mem_read), 32'd0);
`else
    check("ill_decode_done", 32'(instr_done), 32'd1);
    cyc();
    check("ill_nop_fetch", 32'(state), 32'd0);
    check("ill_nop_done_clr", 32'(instr_done), 32'd0);
`endif
    rst_n = 1'b0;
    #2;
    check("ill_rst_state", 32'(state), 32'd0);
    #2 rst_n = 1'b1;
    cyc();

    // sw with reset asserted inside MEMWR
    opcode = 6'h2b;
    cyc(); cyc();
    mem_ready = 1'b0;
    cyc();
    #1;
    check("sw_memwr_state", 32'(state), 32'd5);
    check("sw_memwr_wr", 32'(mem_write), 32'd1);
    check("sw_memwr_done", 32'(instr_done), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("sw_rst_state", 32'(state), 32'd0);
    check("sw_rst_mem_write", 32'(mem_write), 32'd0);
    check("sw_rst_reg_write", 32'(reg_write), 32'd0);
    #1 rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    check("sw_rel_state", 32'(state), 32'd0);
    check("sw_rel_ir_write", 32'(ir_write), 32'd1);
    cyc();
    check("sw_rel_decode", 32'(state), 32'd1);

    // WAIT_LIMIT = 2 timeout in FETCH, then completion exactly at the limit
    rst_n = 1'b0; mem_ready_t = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    irw_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("to_c%0d_state", c), 32'(state_t), 32'd0);
      check($sformatf("to_c%0d_pulse", c), 32'(mem_timeout_t), (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("to_c%0d_pc_en", c), 32'(pc_en_t), 32'd0);
      irw_cnt += int'(ir_write_t);
      cyc();
    end
    check("to_ir_write_never", 32'(irw_cnt), 32'd0);
    cyc();
    mem_ready_t = 1'b1;
    #1;
    check("to_edge_no_pulse", 32'(mem_timeout_t), 32'd0);
    check("to_edge_ir_write", 32'(ir_write_t), 32'd1);
    cyc();
    check("to_edge_decode", 32'(state_t), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
